// File: rtl/peak_pos_tracker_if.sv
// Signal bundle between the scan sequencer / servo logic and peak_pos_tracker.
// The master drives the scan controls and samples. The slave returns the committed and running results.
interface peak_pos_tracker_if #(
    parameter int DATA_W = 12,
    parameter int POS_W  = 32,
    parameter int N_AXES = 2,
    parameter int CNT_W  = 16
);
    // Handshake: scan_start and scan_end are single-cycle pulses with no back-pressure.
    // sample_valid qualifies sample/pos_in on each edge. The sequencer must not pulse
    // scan_start again until busy has returned low.
    logic                     scan_start;
    logic                     scan_end;
    logic                     sample_valid;
    logic [DATA_W-1:0]        sample;
    logic [N_AXES*POS_W-1:0]  pos_in;
    logic [DATA_W-1:0]        max_val;
    logic [N_AXES*POS_W-1:0]  max_pos;
    logic [DATA_W-1:0]        run_val;
    logic [CNT_W-1:0]         sample_cnt;
    logic                     busy;
    logic                     new_max;
    logic                     done;
    logic [1:0]               dbg_state;

    modport master (
        output scan_start, scan_end, sample_valid, sample, pos_in,
        input  max_val, max_pos, run_val, sample_cnt, busy, new_max, done, dbg_state
    );

    modport slave (
        input  scan_start, scan_end, sample_valid, sample, pos_in,
        output max_val, max_pos, run_val, sample_cnt, busy, new_max, done, dbg_state
    );
endinterface

// File: rtl/peak_pos_tracker.sv
// Bounded-window peak tracker with a hysteresis threshold. It records the servo position of the
// running peak and commits the peak value and position together when the scan closes.
module peak_pos_tracker #(
    parameter int DATA_W    = 12,
    parameter int POS_W     = 32,
    parameter int N_AXES    = 2,
    parameter int HYST      = 4,
    parameter int POS_RESET = 500,
    parameter int CNT_W     = 16
) (
    input logic CLK,
    input logic RST,
    peak_pos_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [DATA_W:0]              HYST_EXT    = (DATA_W+1)'(HYST);
    localparam logic [POS_W-1:0]             POS_RST_AX  = POS_W'(POS_RESET);
    localparam logic [N_AXES*POS_W-1:0]      POS_RST_VEC = {N_AXES{POS_RST_AX}};

    state_t                    state_q;
    logic [DATA_W-1:0]         max_val_q;
    logic [N_AXES*POS_W-1:0]   max_pos_q;
    logic [DATA_W-1:0]         run_val_q;
    logic [N_AXES*POS_W-1:0]   run_pos_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      first_q;
    logic                      new_max_q;
    logic                      done_q;

    // The threshold is one bit wider than the data, so a peak near full scale blocks later accepts instead of wrapping.
    logic [DATA_W:0] thresh;
    logic            accept;

    always_comb begin
        thresh = {1'b0, run_val_q} + HYST_EXT;
        accept = first_q || ({1'b0, bus.sample} >= thresh);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            max_val_q <= '0;
            max_pos_q <= POS_RST_VEC;
            run_val_q <= '0;
            run_pos_q <= POS_RST_VEC;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            new_max_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            new_max_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.scan_start) begin
                        state_q   <= SCAN;
                        run_val_q <= '0;
                        run_pos_q <= max_pos_q;
                        cnt_q     <= '0;
                        first_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.scan_start) begin
                        run_val_q <= '0;
                        run_pos_q <= max_pos_q;
                        cnt_q     <= '0;
                        first_q   <= 1'b1;
                    end else begin
                        if (bus.sample_valid) begin
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                            if (accept) begin
                                run_val_q <= bus.sample;
                                run_pos_q <= bus.pos_in;
                                first_q   <= 1'b0;
                                new_max_q <= 1'b1;
                            end
                        end
                        if (bus.scan_end) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    // An empty scan leaves the previous commit in place.
                    if (cnt_q != '0) begin
                        max_val_q <= run_val_q;
                        max_pos_q <= run_pos_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.max_val    = max_val_q;
    assign bus.max_pos    = max_pos_q;
    assign bus.run_val    = run_val_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.new_max    = new_max_q;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_peak_pos_tracker.sv
// Directed bench for peak_pos_tracker. It uses hand-computed expectations for hysteresis, empty
// scans, top of range, simultaneous events and reset in the middle of a scan.
module tb_peak_pos_tracker;
  localparam int DATA_W = 12;
  localparam int POS_W  = 32;
  localparam int N_AXES = 2;
  localparam int CNT_W  = 16;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;
  int   nm_cnt;

  peak_pos_tracker_if #(.DATA_W(DATA_W), .POS_W(POS_W), .N_AXES(N_AXES), .CNT_W(CNT_W)) bus ();

  peak_pos_tracker #(
    .DATA_W(DATA_W), .POS_W(POS_W), .N_AXES(N_AXES),
    .HYST(4), .POS_RESET(500), .CNT_W(CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] pk(input int h, input int v);
    logic [31:0] hh;
    logic [31:0] vv;
    hh = 32'(h);
    vv = 32'(v);
    return {vv, hh};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, then sample 1ns after the rising edge
  task automatic cyc(input logic st, input logic en, input logic v, input int s, input logic [63:0] p);
    @(negedge CLK);
    bus.scan_start   = st;
    bus.scan_end     = en;
    bus.sample_valid = v;
    bus.sample       = DATA_W'(s);
    bus.pos_in       = p;
    @(posedge CLK);
    #1;
    if (bus.new_max === 1'b1) nm_cnt++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 0, 64'd0);
  endtask

  task automatic smp(input int s, input int h, input int v);
    cyc(1'b0, 1'b0, 1'b1, s, pk(h, v));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nm_cnt  = 0;
    bus.scan_start = 0; bus.scan_end = 0; bus.sample_valid = 0;
    bus.sample = '0; bus.pos_in = '0;

    // reset
    RST = 1'b1;
    idle(); idle();
    check("rst_max_val", 64'(bus.max_val), 64'd0);
    check("rst_max_pos", bus.max_pos, pk(500, 500));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_cnt", 64'(bus.sample_cnt), 64'd0);
    check("rst_run_val", 64'(bus.run_val), 64'd0);
    RST = 1'b0;
    idle();

    // hysteresis scan
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    check("hy_busy", 64'(bus.busy), 64'd1);
    nm_cnt = 0;
    smp(100, 10, 1);
    check("hy_nm_first", 64'(bus.new_max), 64'd1);
    smp(300, 20, 2);
    smp(250, 30, 3);
    check("hy_nm_lower", 64'(bus.new_max), 64'd0);
    smp(302, 40, 4);
    check("hy_nm_sub_hyst", 64'(bus.new_max), 64'd0);
    smp(310, 50, 5);
    check("hy_run_val", 64'(bus.run_val), 64'd310);
    check("hy_cnt", 64'(bus.sample_cnt), 64'd5);
    check("hy_nm_count", 64'(nm_cnt), 64'd3);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    check("hy_commit_done0", 64'(bus.done), 64'd0);
    check("hy_commit_busy", 64'(bus.busy), 64'd1);
    check("hy_max_unchanged", 64'(bus.max_val), 64'd0);
    idle();
    check("hy_done", 64'(bus.done), 64'd1);
    check("hy_idle_busy", 64'(bus.busy), 64'd0);
    check("hy_max_val", 64'(bus.max_val), 64'd310);
    check("hy_max_pos", bus.max_pos, pk(50, 5));
    idle();
    check("hy_done_pulse", 64'(bus.done), 64'd0);

    // empty scan
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    idle();
    check("em_done", 64'(bus.done), 64'd1);
    check("em_max_val", 64'(bus.max_val), 64'd310);
    check("em_max_pos", bus.max_pos, pk(50, 5));
    check("em_cnt", 64'(bus.sample_cnt), 64'd0);

    // top of range: 4093+4 exceeds 4095, so 4095 is rejected
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(4093, 7, 7);
    smp(4095, 8, 8);
    check("top_nm_reject", 64'(bus.new_max), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    idle();
    check("top_max_val", 64'(bus.max_val), 64'd4093);
    check("top_max_pos", bus.max_pos, pk(7, 7));
    check("top_cnt", 64'(bus.sample_cnt), 64'd2);
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(0, 1, 2);
    check("zero_nm", 64'(bus.new_max), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    idle();
    check("zero_max_val", 64'(bus.max_val), 64'd0);
    check("zero_max_pos", bus.max_pos, pk(1, 2));

    // sample coincident with scan_end is included
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(800, 3, 3);
    cyc(1'b0, 1'b1, 1'b1, 900, pk(9, 9));
    check("se_run_val", 64'(bus.run_val), 64'd900);
    idle();
    check("se_max_val", 64'(bus.max_val), 64'd900);
    check("se_max_pos", bus.max_pos, pk(9, 9));
    check("se_cnt", 64'(bus.sample_cnt), 64'd2);

    // restart mid-scan drops the sample; scan_start during COMMIT is ignored
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(600, 4, 4);
    cyc(1'b1, 1'b1, 1'b1, 1000, pk(5, 5));
    check("rs_run_val", 64'(bus.run_val), 64'd0);
    check("rs_cnt", 64'(bus.sample_cnt), 64'd0);
    check("rs_nm", 64'(bus.new_max), 64'd0);
    check("rs_busy", 64'(bus.busy), 64'd1);
    smp(200, 6, 6);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    check("rs_done", 64'(bus.done), 64'd1);
    check("rs_max_val", 64'(bus.max_val), 64'd200);
    check("rs_max_pos", bus.max_pos, pk(6, 6));
    idle();
    check("rs_start_in_commit_ignored", 64'(bus.busy), 64'd0);

    // reset mid-scan
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(700, 11, 11);
    check("mr_run_val", 64'(bus.run_val), 64'd700);
    RST = 1'b1;
    idle();
    check("mr_max_val", 64'(bus.max_val), 64'd0);
    check("mr_max_pos", bus.max_pos, pk(500, 500));
    check("mr_run_val0", 64'(bus.run_val), 64'd0);
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_cnt", 64'(bus.sample_cnt), 64'd0);
    check("mr_done", 64'(bus.done), 64'd0);
    RST = 1'b0;
    idle();
    check("mr_done_after", 64'(bus.done), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 0, 64'd0);
    smp(50, 12, 13);
    cyc(1'b0, 1'b1, 1'b0, 0, 64'd0);
    idle();
    check("mr_scan_done", 64'(bus.done), 64'd1);
    check("mr_scan_max_val", 64'(bus.max_val), 64'd50);
    check("mr_scan_max_pos", bus.max_pos, pk(12, 13));
    check("mr_dbg_state", 64'(bus.dbg_state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
